// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus widths, tag encoding (tag = producer index), index sizing.
package cdb_arbiter_pkg;

  localparam int CDB_DATA_WIDTH     = 4;
  localparam int CDB_TAG_WIDTH      = 4;
  localparam int CDB_NUM_PRODUCERS  = 4;

  // Bits needed to hold a producer index; at least one so single-producer builds still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Listeners match on this encoding, so keep it the one place a tag is formed.
  function automatic int unsigned tag_of(input int unsigned producer_idx);
    return producer_idx;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Purely combinational round-robin picker: first request at or after ptr wins.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  logic          found;
  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest active request overwrites the rest.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    any   = en & found;
    grant = '0;
    if (any) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin accept among producers, registered broadcast one cycle later.
// Holds the rotating pointer, the output registers and the result mux.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = CDB_DATA_WIDTH,
  parameter int CDB_TAG_WIDTH = cdb_arbiter_pkg::CDB_TAG_WIDTH,
  parameter int NUM_PRODUCERS = CDB_NUM_PRODUCERS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PRODUCERS-1:0]        req_valid,
  input  logic [NUM_PRODUCERS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PRODUCERS-1:0]        req_accepted,
  input  logic                            grant_en,
  output logic                            cdb_valid,
  output logic [CDB_TAG_WIDTH-1:0]        cdb_tag,
  output logic [DATA_WIDTH-1:0]           cdb_data
);

  localparam int PW = idx_width(NUM_PRODUCERS);

  logic [PW-1:0]            ptr;
  logic [PW-1:0]            ptr_next;
  logic [PW-1:0]            winner;
  logic                     any_grant;
  logic [NUM_PRODUCERS-1:0] grant;
  logic [DATA_WIDTH-1:0]    sel_data;

  // Gating with rst_n keeps accepts low for the whole reset, not just after the first edge.
  rr_priority_picker #(
    .N  (NUM_PRODUCERS),
    .PW (PW)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (grant_en & rst_n),
    .grant  (grant),
    .winner (winner),
    .any    (any_grant)
  );

  assign req_accepted = grant;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_PRODUCERS; i++) begin
      if (winner == PW'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign ptr_next = (winner == PW'(NUM_PRODUCERS - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else if (any_grant) begin
      ptr       <= ptr_next;
      cdb_valid <= 1'b1;
      cdb_tag   <= CDB_TAG_WIDTH'(tag_of(32'(winner)));
      cdb_data  <= sel_data;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter against a rotating-priority reference model.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_accepted;
  logic        grant_en;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [3:0]  cdb_data;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_ptr;
  logic       m_valid;
  logic [3:0] m_tag;
  logic [3:0] m_data;
  logic [3:0] exp_acc;
  int         exp_win;

  cdb_arbiter #(
    .DATA_WIDTH    (4),
    .CDB_TAG_WIDTH (4),
    .NUM_PRODUCERS (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_accepted (req_accepted),
    .grant_en     (grant_en),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_tag = 4'd0; m_data = 4'd0;
  endtask

  // Drive inputs (away from the edge) and work out what should be accepted.
  task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic en);
    req_valid = v;
    req_data  = d;
    grant_en  = en;
    exp_win   = model_pick(v, m_ptr);
    exp_acc   = 4'b0000;
    if (en && rst_n && exp_win >= 0) exp_acc[exp_win] = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (exp_acc != 4'b0000) begin
      m_valid = 1'b1;
      m_tag   = 4'(exp_win);
      m_data  = req_data[exp_win*4 +: 4];
      m_ptr   = (exp_win + 1) % 4;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(4'b1111, 16'h4321, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({cdb_valid, cdb_tag, cdb_data} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 000", {cdb_valid, cdb_tag, cdb_data});
    end
    total++;
    if (req_accepted !== 4'b0000) begin
      bad++; $display("FAIL reset_accept: got %b want 0000", req_accepted);
    end
    rst_n = 1'b1;
    drive(4'b1111, 16'h4321, 1'b1);
    total++;
    if (req_accepted !== 4'b0001) begin
      bad++; $display("FAIL reset_first_accept: got %b want 0001", req_accepted);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd0 || cdb_data !== 4'h1) begin
      bad++; $display("FAIL reset_first_bcast: got v=%b t=%h d=%h want v=1 t=0 d=1", cdb_valid, cdb_tag, cdb_data);
    end
  endtask

  task automatic test_single();
    logic [15:0] d;
    d = 16'($urandom);
    d[11:8] = 4'hA;
    drive(4'b0100, d, 1'b1);
    total++;
    if (req_accepted !== 4'b0100) begin
      bad++; $display("FAIL single_accept: got %b want 0100", req_accepted);
    end
    tick();
    drive(4'b0000, 16'($urandom), 1'b1);
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2 || cdb_data !== 4'hA) begin
      bad++; $display("FAIL single_bcast: got v=%b t=%h d=%h want v=1 t=2 d=a", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'd2 || cdb_data !== 4'hA) begin
      bad++; $display("FAIL single_idle_hold: got v=%b t=%h d=%h want v=0 t=2 d=a", cdb_valid, cdb_tag, cdb_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 16'($urandom), 1'b1);
      total++;
      if (req_accepted !== exp_acc) begin
        bad++; $display("FAIL rr_accept[%0d]: got %b want %b", i, req_accepted, exp_acc);
      end
      tick();
      total++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 4'(i % 4) || cdb_data !== m_data) begin
        bad++; $display("FAIL rr_bcast[%0d]: got v=%b t=%h d=%h want v=1 t=%h d=%h", i, cdb_valid, cdb_tag, cdb_data, i % 4, m_data);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] want [3];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0001;
    drive(4'b0100, 16'($urandom), 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 16'($urandom), 1'b1);
      total++;
      if (req_accepted !== want[i]) begin
        bad++; $display("FAIL wrap_accept[%0d]: got %b want %b", i, req_accepted, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    drive(4'b0110, 16'($urandom), 1'b0);
    total++;
    if (req_accepted !== 4'b0000) begin
      bad++; $display("FAIL stall_accept: got %b want 0000", req_accepted);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin
      bad++; $display("FAIL stall_valid: got %b want 0", cdb_valid);
    end
    drive(4'b0110, 16'($urandom), 1'b1);
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd1) begin
      bad++; $display("FAIL stall_resume1: got v=%b t=%h want v=1 t=1", cdb_valid, cdb_tag);
    end
    drive(4'b0110, 16'($urandom), 1'b1);
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd2) begin
      bad++; $display("FAIL stall_resume2: got v=%b t=%h want v=1 t=2", cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_mid_reset();
    drive(4'b1000, 16'($urandom), 1'b1);
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3) begin
      bad++; $display("FAIL midrst_setup: got v=%b t=%h want v=1 t=3", cdb_valid, cdb_tag);
    end
    drive(4'b1111, 16'($urandom), 1'b1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({cdb_valid, cdb_tag, cdb_data} !== 9'd0 || req_accepted !== 4'b0000) begin
      bad++; $display("FAIL midrst_clear: got out=%h acc=%b want out=000 acc=0000", {cdb_valid, cdb_tag, cdb_data}, req_accepted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 16'($urandom), 1'b1);
    total++;
    if (req_accepted !== 4'b0001) begin
      bad++; $display("FAIL midrst_restart: got %b want 0001", req_accepted);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'd0) begin
      bad++; $display("FAIL midrst_bcast: got v=%b t=%h want v=1 t=0", cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom), 16'($urandom), ($urandom_range(0, 9) < 8));
      total++;
      if (req_accepted !== exp_acc) begin
        bad++; $display("FAIL rand_accept[%0d]: got %b want %b", i, req_accepted, exp_acc);
      end
      tick();
      total++;
      if (cdb_valid !== m_valid || cdb_tag !== m_tag || cdb_data !== m_data) begin
        bad++; $display("FAIL rand_bcast[%0d]: got v=%b t=%h d=%h want v=%b t=%h d=%h", i, cdb_valid, cdb_tag, cdb_data, m_valid, m_tag, m_data);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 16'h0000;
    grant_en  = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_stall();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
